// File: rtl/spi_tx_feeder.sv
// SPI transmit feeder: buffers 16-bit words and presents them byte-wise, MSB first.
// Define SPI_TX_FEEDER_CHECKSUM_EN to append a mod-256 checksum byte after every FRAME_WORDS words.
module spi_tx_feeder #(
  parameter int          DEPTH       = 16,
  parameter int          FRAME_WORDS = 8,
  parameter logic [7:0]  IDLE_BYTE   = 8'h00
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [15:0]                meas_data,
  input  logic                       meas_valid,
  output logic                       meas_ready,
  input  logic                       clear,
  output logic [7:0]                 tx_data,
  output logic                       tx_enable,
  input  logic                       byte_sent,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Elaboration-time guard: an illegal configuration names a module that does not exist.
  if (DEPTH < 2 || (1 << AW) != DEPTH || FRAME_WORDS < 1) begin : g_bad_param
    spi_tx_feeder_bad_parameter u_bad ();
  end

`ifdef SPI_TX_FEEDER_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_HI, S_LO, S_CSUM} state_t;
  localparam int CW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_WORDS - 1);
  logic [CW-1:0] cnt_q;
  logic [7:0]    sum_q, sum_add;
  logic          frame_last;
  assign sum_add    = sum_q + tx_data_q;
  assign frame_last = (cnt_q == CNT_LAST);
`else
  typedef enum logic [1:0] {S_IDLE, S_HI, S_LO} state_t;
`endif

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          ready_q;
  state_t        state_q;
  logic [7:0]    lo_q, tx_data_q;
  logic          tx_en_q, uf_q;
  logic          push, pop, not_empty;
  logic [15:0]   pop_word;

  assign not_empty = (level_q != '0);
  assign push      = meas_valid && ready_q && !clear;
  assign pop_word  = mem_q[rd_ptr_q];

  always_comb begin
    pop = 1'b0;
    if (!clear) begin
      case (state_q)
        S_IDLE: pop = not_empty;
`ifdef SPI_TX_FEEDER_CHECKSUM_EN
        S_LO:   pop = byte_sent && !frame_last && not_empty;
        S_CSUM: pop = byte_sent && not_empty;
`else
        S_LO:   pop = byte_sent && not_empty;
`endif
        default: pop = 1'b0;
      endcase
    end
  end

  assign level_d = level_q + LW'(push) - LW'(pop);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= meas_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b1;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      // ready follows the post-edge level so a full FIFO refuses the very next word
      ready_q <= (level_d != LW'(DEPTH));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      lo_q      <= '0;
      tx_data_q <= IDLE_BYTE;
      tx_en_q   <= 1'b0;
      uf_q      <= 1'b0;
`ifdef SPI_TX_FEEDER_CHECKSUM_EN
      cnt_q     <= '0;
      sum_q     <= '0;
`endif
    end else if (clear) begin
      state_q   <= S_IDLE;
      lo_q      <= '0;
      tx_data_q <= IDLE_BYTE;
      tx_en_q   <= 1'b0;
      uf_q      <= 1'b0;
`ifdef SPI_TX_FEEDER_CHECKSUM_EN
      cnt_q     <= '0;
      sum_q     <= '0;
`endif
    end else begin
      uf_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          uf_q <= byte_sent;
          if (pop) begin
            state_q   <= S_HI;
            tx_data_q <= pop_word[15:8];
            lo_q      <= pop_word[7:0];
            tx_en_q   <= 1'b1;
          end
        end
        S_HI: if (byte_sent) begin
          state_q   <= S_LO;
          tx_data_q <= lo_q;
`ifdef SPI_TX_FEEDER_CHECKSUM_EN
          sum_q     <= sum_add;
`endif
        end
        S_LO: if (byte_sent) begin
`ifdef SPI_TX_FEEDER_CHECKSUM_EN
          sum_q <= sum_add;
          cnt_q <= frame_last ? '0 : cnt_q + 1'b1;
          if (frame_last) begin
            state_q   <= S_CSUM;
            tx_data_q <= sum_add;
          end else
`endif
          if (pop) begin
            state_q   <= S_HI;
            tx_data_q <= pop_word[15:8];
            lo_q      <= pop_word[7:0];
          end else begin
            state_q   <= S_IDLE;
            tx_data_q <= IDLE_BYTE;
            tx_en_q   <= 1'b0;
          end
        end
`ifdef SPI_TX_FEEDER_CHECKSUM_EN
        S_CSUM: if (byte_sent) begin
          sum_q <= '0;
          cnt_q <= '0;
          if (pop) begin
            state_q   <= S_HI;
            tx_data_q <= pop_word[15:8];
            lo_q      <= pop_word[7:0];
          end else begin
            state_q   <= S_IDLE;
            tx_data_q <= IDLE_BYTE;
            tx_en_q   <= 1'b0;
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign meas_ready = ready_q;
  assign fifo_level = level_q;
  assign tx_data    = tx_data_q;
  assign tx_enable  = tx_en_q;
  assign underflow  = uf_q;

endmodule

// File: tb/tb_spi_tx_feeder.sv
// Self-checking bench for spi_tx_feeder: vector table, directed corners, random traffic vs a queue model.
module tb_spi_tx_feeder;
  localparam int DEPTH = 16;
  localparam int FW    = 2;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   meas_data = '0;
  logic          meas_valid = 1'b0;
  logic          meas_ready;
  logic          clear = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_enable;
  logic          byte_sent = 1'b0;
  logic [LW-1:0] fifo_level;
  logic          underflow;

  spi_tx_feeder #(.DEPTH(DEPTH), .FRAME_WORDS(FW), .IDLE_BYTE(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .meas_data(meas_data), .meas_valid(meas_valid),
    .meas_ready(meas_ready), .clear(clear), .tx_data(tx_data), .tx_enable(tx_enable),
    .byte_sent(byte_sent), .fifo_level(fifo_level), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: word queue, queue of bytes still to present for the current word.
  logic [15:0] m_fifo[$];
  logic [7:0]  m_pend[$];
  int          m_tag[$];   // 0 = MSB byte, 1 = LSB byte, 2 = checksum
  logic [7:0]  m_sum;
  int          m_wc;
  logic        m_ready, m_uf;

`ifdef SPI_TX_FEEDER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete(); m_pend.delete(); m_tag.delete();
    m_sum = '0; m_wc = 0; m_ready = 1'b1; m_uf = 1'b0;
  endtask

  task automatic model_edge(input logic v, input logic [15:0] d, input logic bs, input logic clr);
    logic rdy_b;
    logic [15:0] w;
    logic [7:0] b;
    int t;
    rdy_b = m_ready;
    if (clr) begin
      model_reset();
      return;
    end
    m_uf = bs && (m_pend.size() == 0);
    if (bs && m_pend.size() > 0) begin
      b = m_pend.pop_front();
      t = m_tag.pop_front();
      if (t != 2) m_sum = m_sum + b;
      if (t == 1) begin
        m_wc++;
        if (CSUM && m_wc == FW) begin
          m_pend.push_back(m_sum);
          m_tag.push_back(2);
        end
      end else if (t == 2) begin
        m_sum = '0;
        m_wc = 0;
      end
    end
    if (m_pend.size() == 0 && m_fifo.size() > 0) begin
      w = m_fifo.pop_front();
      m_pend.push_back(w[15:8]); m_tag.push_back(0);
      m_pend.push_back(w[7:0]);  m_tag.push_back(1);
    end
    if (v && rdy_b) m_fifo.push_back(d);
    m_ready = (m_fifo.size() < DEPTH);
  endtask

  task automatic compare_model();
    check("tx_enable", 16'(tx_enable), 16'(m_pend.size() > 0));
    check("tx_data", 16'(tx_data), 16'((m_pend.size() > 0) ? m_pend[0] : 8'h00));
    check("fifo_level", 16'(fifo_level), 16'(m_fifo.size()));
    check("meas_ready", 16'(meas_ready), 16'(m_ready));
    check("underflow", 16'(underflow), 16'(m_uf));
  endtask

  // Drive one cycle of inputs, advance one edge, compare against the model.
  task automatic step(input logic v, input logic [15:0] d, input logic bs, input logic clr);
    meas_valid = v; meas_data = d; byte_sent = bs; clear = clr;
    @(posedge clk);
    model_edge(v, d, bs, clr);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    meas_valid = 1'b0; byte_sent = 1'b0; clear = 1'b0;
    rst_n = 1'b0;
    #12;
    model_reset();
    check("rst tx_data", 16'(tx_data), 16'h00);
    check("rst tx_enable", 16'(tx_enable), 16'h0);
    check("rst fifo_level", 16'(fifo_level), 16'h0);
    check("rst meas_ready", 16'(meas_ready), 16'h1);
    check("rst underflow", 16'(underflow), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic v; logic [15:0] d; logic bs; logic clr;
    logic [7:0] e_data; logic e_en; logic [LW-1:0] e_lvl; logic e_rdy; logic e_uf;
  } vec_t;

  vec_t vt[10];
  logic [15:0] words[20];
  logic [7:0] got[$];
  logic [7:0] exp_b;

  initial begin
    vt[0] = '{1'b1, 16'hA55A, 1'b0, 1'b0, 8'h00, 1'b0, 5'd1, 1'b1, 1'b0};
    vt[1] = '{1'b0, 16'h0000, 1'b0, 1'b0, 8'hA5, 1'b1, 5'd0, 1'b1, 1'b0};
    vt[2] = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'h5A, 1'b1, 5'd0, 1'b1, 1'b0};
    vt[3] = '{1'b0, 16'h0000, 1'b0, 1'b0, 8'h5A, 1'b1, 5'd0, 1'b1, 1'b0};
    vt[4] = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0};
    vt[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b1};
    vt[6] = '{1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0};
    vt[7] = '{1'b1, 16'hBEEF, 1'b0, 1'b0, 8'h00, 1'b0, 5'd1, 1'b1, 1'b0};
    vt[8] = '{1'b1, 16'hCAFE, 1'b0, 1'b1, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0};
    vt[9] = '{1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(vt[i].v, vt[i].d, vt[i].bs, vt[i].clr);
      check($sformatf("vec%0d tx_data", i), 16'(tx_data), 16'(vt[i].e_data));
      check($sformatf("vec%0d tx_enable", i), 16'(tx_enable), 16'(vt[i].e_en));
      check($sformatf("vec%0d fifo_level", i), 16'(fifo_level), 16'(vt[i].e_lvl));
      check($sformatf("vec%0d meas_ready", i), 16'(meas_ready), 16'(vt[i].e_rdy));
      check($sformatf("vec%0d underflow", i), 16'(underflow), 16'(vt[i].e_uf));
    end

    // Fill past capacity with no byte_sent, then drain and verify order.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      words[i] = 16'h1000 + 16'(i * 16'h0111);
      step(1'b1, words[i], 1'b0, 1'b0);
    end
    check("full level", 16'(fifo_level), 16'd16);
    check("full meas_ready", 16'(meas_ready), 16'h0);
    got.delete();
    for (int i = 0; i < 40 && tx_enable; i++) begin
      got.push_back(tx_data);
      step(1'b0, 16'h0, 1'b1, 1'b0);
    end
    step(1'b0, 16'h0, 1'b0, 1'b0);
`ifndef SPI_TX_FEEDER_CHECKSUM_EN
    check("drain count", 16'(got.size()), 16'd34);
    for (int i = 0; i < got.size() && i < 34; i++) begin
      exp_b = (i % 2 == 0) ? words[i/2][15:8] : words[i/2][7:0];
      check($sformatf("drain byte%0d", i), 16'(got[i]), 16'(exp_b));
    end
`endif

    // clear mid-word (LSB byte showing, 5 queued) together with a push.
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 16'h2000 + 16'(i), 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    check("pre-clear tx_data", 16'(tx_data), 16'h00);
    check("pre-clear level", 16'(fifo_level), 16'd5);
    step(1'b1, 16'h7777, 1'b1, 1'b1);
    check("clear level", 16'(fifo_level), 16'd0);
    check("clear tx_enable", 16'(tx_enable), 16'h0);
    check("clear tx_data", 16'(tx_data), 16'h00);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    check("clear drop push", 16'(fifo_level), 16'd0);

`ifdef SPI_TX_FEEDER_CHECKSUM_EN
    begin
      logic [7:0] exp_cs[10];
      exp_cs = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0A, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFE};
      do_reset();
      step(1'b1, 16'h0102, 1'b0, 1'b0);
      step(1'b1, 16'h0304, 1'b0, 1'b0);
      step(1'b0, 16'h0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
        check($sformatf("csum byte%0d", i), 16'(tx_data), 16'(exp_cs[i]));
        step(1'b0, 16'h0, 1'b1, 1'b0);
      end
      check("csum idle", 16'(tx_enable), 16'h0);
      step(1'b1, 16'hFFFF, 1'b0, 1'b0);
      step(1'b1, 16'h0000, 1'b0, 1'b0);
      step(1'b0, 16'h0, 1'b0, 1'b0);
      for (int i = 5; i < 10; i++) begin
        check($sformatf("csum byte%0d", i), 16'(tx_data), 16'(exp_cs[i]));
        step(1'b0, 16'h0, 1'b1, 1'b0);
      end
      check("csum2 idle", 16'(tx_enable), 16'h0);
    end
`endif

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++)
      step(($urandom % 3) != 0, 16'($urandom), ($urandom % 3) == 0, ($urandom % 60) == 0);

    // Asynchronous reset while a word is in flight with 3 queued.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 16'h3000 + 16'(i), 1'b0, 1'b0);
    check("pre-rst tx_enable", 16'(tx_enable), 16'h1);
    check("pre-rst level", 16'(fifo_level), 16'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst tx_enable", 16'(tx_enable), 16'h0);
    check("async rst level", 16'(fifo_level), 16'd0);
    check("async rst meas_ready", 16'(meas_ready), 16'h1);
    check("async rst tx_data", 16'(tx_data), 16'h00);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 16'h4242, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    check("post-rst tx_data", 16'(tx_data), 16'h42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_tx_feeder.md
Name: spi_tx_feeder

Overview:
- Upstream stage of the SPI slave transmitter.
- Buffers 16-bit compressive-sensing measurement words in a FIFO and splits each into two bytes, MSB byte first.
- Presents one byte at a time on tx_data and advances on each byte_sent pulse from the transmitter.
- Drives tx_enable, which gates the transmitter's shifting.

Parameters:
DEPTH, 16, FIFO depth in 16-bit words; power of 2, minimum 2
FRAME_WORDS, 8, words per frame; used by the checksum feature, minimum 1
IDLE_BYTE, 8'h00, byte presented when no data is available

Ports:
clk  input  1  system clock; all logic on its rising edge
rst_n  input  1  reset, asynchronous, active-low
meas_data  input  16  measurement word to enqueue
meas_valid  input  1  meas_data valid
meas_ready  output  1  FIFO can accept a word (not full)
clear  input  1  synchronous flush of FIFO, sequencer and frame count
tx_data  output  8  byte for the SPI transmitter
tx_enable  output  1  a real (non-idle) byte is on tx_data
byte_sent  input  1  one-cycle pulse: current byte fully shifted out
fifo_level  output  clog2(DEPTH)+1  words currently stored
underflow  output  1  one-cycle pulse: byte_sent seen while IDLE

Behaviour:
- Reset: FIFO empty, fifo_level=0, meas_ready=1, state IDLE, tx_data=IDLE_BYTE, tx_enable=0, underflow=0, frame word count=0, checksum=0.
- Write: push occurs when meas_valid && meas_ready. meas_ready = !full, registered from level, with no combinational path from meas_valid.
- Full: no push, meas_data is ignored, level is unchanged.
- Pointers wrap modulo DEPTH. fifo_level updates the cycle after each push/pop; a simultaneous push and pop leaves the level unchanged.
- States: IDLE, HI, LO, CSUM (CSUM exists only with the optional feature).
- IDLE:
  - If FIFO non-empty, pop a word into the hold register. Next cycle: state=HI, tx_data=word[15:8], tx_enable=1.
  - No bypass: a word pushed into an empty FIFO reaches tx_data 2 cycles after the push edge.
- HI: on byte_sent, next cycle state=LO, tx_data=word[7:0].
- LO, on byte_sent:
  - Frame word count increments, wrapping at FRAME_WORDS.
  - With CHECKSUM_EN and this was word FRAME_WORDS-1: go to CSUM.
  - Otherwise, if FIFO non-empty: pop, go to HI with the new MSB byte.
  - Otherwise: go to IDLE, tx_data=IDLE_BYTE, tx_enable=0.
- Between byte_sent pulses, tx_data and tx_enable are stable.
- byte_sent in IDLE: underflow pulses for 1 cycle the next cycle; state is unchanged.
- clear: next cycle all state is as at reset, except the current meas_ready/level recompute. clear has priority over a push and a byte_sent in the same cycle.
- rst_n asserted mid-byte: immediate return to reset values. The transmitter's partial byte is not re-sent.

Optional Feature:
- Macro: SPI_TX_FEEDER_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum, mod 256, of every byte presented in HI/LO within the current frame.
  - After the LO byte of word FRAME_WORDS-1 is sent, enter CSUM: tx_data=sum, tx_enable=1.
  - On byte_sent in CSUM: sum=0, count=0, then continue as in LO (pop to HI, or IDLE).
  - clear and reset zero the sum.
- Undefined: no CSUM state and no sum register; the frame count is not built. Frames are continuous byte pairs.

Test Plan:
- Reset, then push 16'hA55A with byte_sent idle -> tx_data=8'hA5 with tx_enable=1 two cycles after push; after byte_sent, tx_data=8'h5A; after a second byte_sent, tx_data=8'h00, tx_enable=0, fifo_level=0.
- Push 17 words with DEPTH=16 and no byte_sent -> one word goes to the hold register, 15 queued, 16th and 17th accepted while meas_ready=1. meas_ready drops when level=16 and further meas_valid is ignored; the drained byte order matches push order.
- byte_sent pulse while IDLE -> underflow=1 for exactly 1 cycle, tx_data stays 8'h00, state stays IDLE.
- clear asserted mid-word (state LO, 5 words queued) together with meas_valid -> next cycle fifo_level=0, tx_enable=0, tx_data=8'h00; the pushed word is dropped.
- CHECKSUM_EN, FRAME_WORDS=2, push 16'h0102 and 16'h0304 -> bytes sent are 01,02,03,04,0A; then IDLE. A third word 16'hFFFF starts a new frame, with checksum 8'hFE after the next word.
- rst_n pulsed low in state HI with 3 words queued -> outputs immediately reset (tx_enable=0, fifo_level=0, meas_ready=1) without waiting for clk.
